// File: rtl/nibble_mem_responder.sv
// ---------------------------------------------------------------------------
// nibble_mem_responder
//
// Memory-side responder for the 4-bit accumulator CPU's 8-pin bus. Holds a
// 2**ADDR_W x DATA_W memory that the CPU fetches from and loads from
// combinationally. Stores are decoded by a two-cycle address/data state
// machine. A programming port fills the memory before a run and holds the
// CPU in reset while it does so.
//
// Ports:
//   clk        system clock, shared with the CPU
//   rst_p      asynchronous active-high reset
//   bus_in     CPU output byte: [5:0] address or store data, [6] unused,
//              [7] wcyc (write cycle)
//   bus_out    nibble presented to the CPU data input (combinational)
//   prog_en    programming mode enable
//   prog_we    programming write strobe, only acted on while prog_en is high
//   prog_data  programming data nibble
//   cpu_rst_p  reset to the CPU
//   prog_ptr   current programming pointer
//   wr_pulse   one-cycle pulse after a CPU store commits
//   wr_addr    address of the last committed CPU store
//   err_abort  sticky flag: a store address phase was not followed by data
// ---------------------------------------------------------------------------
module nibble_mem_responder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [7:0]        bus_in,
    output logic [DATA_W-1:0] bus_out,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [DATA_W-1:0] prog_data,
    output logic              cpu_rst_p,
    output logic [ADDR_W-1:0] prog_ptr,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              err_abort
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } wstate_t;

    wstate_t           state;
    wstate_t           state_next;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] waddr_next;
    logic              bus_commit;
    logic              bus_abort;

    logic              wcyc;
    logic [ADDR_W-1:0] bus_addr;

    logic              prog_en_q;
    logic              prog_rise;
    logic [ADDR_W-1:0] ptr_base;
    logic              release_hold;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign wcyc     = bus_in[7];
    assign bus_addr = bus_in[ADDR_W-1:0];

    // Read path: the CPU sees the addressed nibble in the same cycle it puts
    // the address out. Write cycles and programming mode present zero so the
    // CPU never latches stale data while the bus means something else.
    always_comb begin
        bus_out = '0;
        if (!wcyc && !prog_en) begin
            bus_out = mem[bus_addr];
        end
    end

    // Write FSM next-state logic. A wcyc-high cycle in W_IDLE is an address
    // phase; the cycle after it must also be wcyc-high to carry the data,
    // otherwise the store is dropped and flagged. Programming mode parks the
    // FSM in W_IDLE so a half-finished store can never land afterwards.
    always_comb begin
        state_next = state;
        waddr_next = waddr;
        bus_commit = 1'b0;
        bus_abort  = 1'b0;
        if (prog_en) begin
            state_next = W_IDLE;
        end else begin
            case (state)
                W_IDLE: begin
                    if (wcyc) begin
                        waddr_next = bus_addr;
                        state_next = W_DATA;
                    end
                end
                W_DATA: begin
                    state_next = W_IDLE;
                    if (wcyc) begin
                        bus_commit = 1'b1;
                    end else begin
                        bus_abort = 1'b1;
                    end
                end
                default: state_next = W_IDLE;
            endcase
        end
    end

    // Write FSM state and latched store address.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state <= W_IDLE;
            waddr <= '0;
        end else begin
            state <= state_next;
            waddr <= waddr_next;
        end
    end

    // Store status: the pulse follows the commit edge by one cycle, the
    // address of the last commit is held, and an abort stays flagged until
    // the next system reset.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            err_abort <= 1'b0;
        end else begin
            wr_pulse <= bus_commit;
            if (bus_commit) begin
                wr_addr <= waddr;
            end
            if (bus_abort) begin
                err_abort <= 1'b1;
            end
        end
    end

    // A fresh programming session always starts at address 0, even when the
    // first write strobe arrives in the same cycle prog_en rises.
    assign prog_rise = prog_en && !prog_en_q;
    assign ptr_base  = prog_rise ? '0 : prog_ptr;

    // Programming pointer, prog_en history and the post-programming hold.
    // release_hold keeps the CPU in reset for one cycle after prog_en falls so
    // the last programmed word has settled before the first fetch.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            prog_en_q    <= 1'b0;
            prog_ptr     <= '0;
            release_hold <= 1'b0;
        end else begin
            prog_en_q    <= prog_en;
            release_hold <= prog_en_q && !prog_en;
            if (prog_en) begin
                if (prog_we) begin
                    prog_ptr <= ptr_base + PTR_ONE;
                end else begin
                    prog_ptr <= ptr_base;
                end
            end
        end
    end

    // Memory array. Programming and CPU stores never collide because the
    // write FSM cannot commit while prog_en is high.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (prog_en && prog_we) begin
            mem[ptr_base] <= prog_data;
        end else if (bus_commit) begin
            mem[waddr] <= bus_in[DATA_W-1:0];
        end
    end

    assign cpu_rst_p = rst_p || prog_en || release_hold;

endmodule

// File: tb/tb_nibble_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_nibble_mem_responder
//
// Directed self-checking bench for nibble_mem_responder. Each task drives one
// scenario and compares DUT outputs against hand-computed values. Inputs are
// changed 1 time unit after the rising edge and sampled there as well.
// ---------------------------------------------------------------------------
module tb_nibble_mem_responder;

    logic       clk;
    logic       rst_p;
    logic [7:0] bus_in;
    logic [3:0] bus_out;
    logic       prog_en;
    logic       prog_we;
    logic [3:0] prog_data;
    logic       cpu_rst_p;
    logic [5:0] prog_ptr;
    logic       wr_pulse;
    logic [5:0] wr_addr;
    logic       err_abort;

    int checks   = 0;
    int failures = 0;

    nibble_mem_responder #(
        .ADDR_W(6),
        .DATA_W(4)
    ) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .prog_en   (prog_en),
        .prog_we   (prog_we),
        .prog_data (prog_data),
        .cpu_rst_p (cpu_rst_p),
        .prog_ptr  (prog_ptr),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .err_abort (err_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_p     = 1'b1;
        bus_in    = 8'h00;
        prog_en   = 1'b0;
        prog_we   = 1'b0;
        prog_data = 4'h0;
        tick();
        tick();
        checks++;
        if (cpu_rst_p !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_cpu_rst got=%b exp=1", cpu_rst_p);
        end
        checks++;
        if (prog_ptr !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_prog_ptr got=%0d exp=0", prog_ptr);
        end
        checks++;
        if (wr_pulse !== 1'b0 || wr_addr !== 6'd0 || err_abort !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status got=%b/%0d/%b exp=0/0/0", wr_pulse, wr_addr, err_abort);
        end
        checks++;
        if (bus_out !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_read0 got=%h exp=0", bus_out);
        end
        rst_p = 1'b0;
        #1;
        checks++;
        if (cpu_rst_p !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release got=%b exp=0", cpu_rst_p);
        end
        tick();
    endtask

    task automatic test_program();
        prog_en = 1'b1;
        prog_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prog_data = 4'(i + 1);
            #1;
            checks++;
            if (cpu_rst_p !== 1'b1 || bus_out !== 4'h0) begin
                failures++;
                $display("[TB] FAIL prog_hold_%0d got=%b/%h exp=1/0", i, cpu_rst_p, bus_out);
            end
            tick();
        end
        checks++;
        if (prog_ptr !== 6'd6) begin
            failures++;
            $display("[TB] FAIL prog_ptr6 got=%0d exp=6", prog_ptr);
        end
        prog_we = 1'b0;
        prog_en = 1'b0;
        tick();
        checks++;
        if (cpu_rst_p !== 1'b1) begin
            failures++;
            $display("[TB] FAIL prog_release_hold got=%b exp=1", cpu_rst_p);
        end
        tick();
        checks++;
        if (cpu_rst_p !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prog_release_done got=%b exp=0", cpu_rst_p);
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 7; i++) begin
            bus_in = 8'(i);
            #1;
            checks++;
            if (bus_out !== ((i < 6) ? 4'(i + 1) : 4'h0)) begin
                failures++;
                $display("[TB] FAIL read_%0d got=%h exp=%h", i, bus_out, (i < 6) ? 4'(i + 1) : 4'h0);
            end
        end
        bus_in = 8'h03;
        #1;
        checks++;
        if (bus_out !== 4'h4) begin
            failures++;
            $display("[TB] FAIL read_03 got=%h exp=4", bus_out);
        end
        bus_in = 8'h83;
        #1;
        checks++;
        if (bus_out !== 4'h0) begin
            failures++;
            $display("[TB] FAIL read_wcyc got=%h exp=0", bus_out);
        end
        bus_in = 8'h00;
        tick();
    endtask

    task automatic test_store();
        bus_in = 8'h8A;
        tick();
        checks++;
        if (wr_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_addr_phase_pulse got=%b exp=0", wr_pulse);
        end
        bus_in = 8'h8C;
        tick();
        checks++;
        if (wr_pulse !== 1'b1 || wr_addr !== 6'd10) begin
            failures++;
            $display("[TB] FAIL store_commit got=%b/%0d exp=1/10", wr_pulse, wr_addr);
        end
        bus_in = 8'h0A;
        tick();
        checks++;
        if (wr_pulse !== 1'b0 || bus_out !== 4'hC) begin
            failures++;
            $display("[TB] FAIL store_readback got=%b/%h exp=0/c", wr_pulse, bus_out);
        end
    endtask

    task automatic test_back_to_back();
        bus_in = 8'h91;
        tick();
        bus_in = 8'hB7;
        tick();
        checks++;
        if (wr_pulse !== 1'b1 || wr_addr !== 6'd17) begin
            failures++;
            $display("[TB] FAIL b2b_first got=%b/%0d exp=1/17", wr_pulse, wr_addr);
        end
        bus_in = 8'h92;
        tick();
        checks++;
        if (wr_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_gap_pulse got=%b exp=0", wr_pulse);
        end
        bus_in = 8'h89;
        tick();
        checks++;
        if (wr_pulse !== 1'b1 || wr_addr !== 6'd18) begin
            failures++;
            $display("[TB] FAIL b2b_second got=%b/%0d exp=1/18", wr_pulse, wr_addr);
        end
        bus_in = 8'h11;
        #1;
        checks++;
        if (bus_out !== 4'h7) begin
            failures++;
            $display("[TB] FAIL b2b_read17 got=%h exp=7", bus_out);
        end
        bus_in = 8'h12;
        #1;
        checks++;
        if (bus_out !== 4'h9) begin
            failures++;
            $display("[TB] FAIL b2b_read18 got=%h exp=9", bus_out);
        end
        tick();
    endtask

    task automatic test_abort();
        checks++;
        if (err_abort !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_before got=%b exp=0", err_abort);
        end
        bus_in = 8'h85;
        tick();
        bus_in = 8'h05;
        tick();
        checks++;
        if (err_abort !== 1'b1 || wr_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_flag got=%b/%b exp=1/0", err_abort, wr_pulse);
        end
        bus_in = 8'h00;
        tick();
        tick();
        bus_in = 8'h05;
        #1;
        checks++;
        if (bus_out !== 4'h6 || err_abort !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_sticky got=%h/%b exp=6/1", bus_out, err_abort);
        end
        bus_in = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        prog_en = 1'b1;
        prog_we = 1'b1;
        for (int i = 0; i < 65; i++) begin
            prog_data = 4'(i % 16);
            tick();
        end
        checks++;
        if (prog_ptr !== 6'd1) begin
            failures++;
            $display("[TB] FAIL wrap_ptr got=%0d exp=1", prog_ptr);
        end
        prog_we = 1'b0;
        prog_en = 1'b0;
        tick();
        tick();
        bus_in = 8'h00;
        #1;
        checks++;
        if (bus_out !== 4'h0) begin
            failures++;
            $display("[TB] FAIL wrap_read0 got=%h exp=0", bus_out);
        end
        bus_in = 8'h3F;
        #1;
        checks++;
        if (bus_out !== 4'hF) begin
            failures++;
            $display("[TB] FAIL wrap_read63 got=%h exp=f", bus_out);
        end
        bus_in = 8'h0A;
        #1;
        checks++;
        if (bus_out !== 4'hA) begin
            failures++;
            $display("[TB] FAIL wrap_read10 got=%h exp=a", bus_out);
        end
        checks++;
        if (err_abort !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_err_sticky got=%b exp=1", err_abort);
        end
        bus_in = 8'h00;
        tick();
    endtask

    task automatic test_async_reset();
        bus_in = 8'h8A;
        tick();
        bus_in = 8'h8F;
        #2;
        rst_p = 1'b1;
        #1;
        checks++;
        if (cpu_rst_p !== 1'b1 || err_abort !== 1'b0 || prog_ptr !== 6'd0) begin
            failures++;
            $display("[TB] FAIL async_rst_immediate got=%b/%b/%0d exp=1/0/0", cpu_rst_p, err_abort, prog_ptr);
        end
        bus_in = 8'h0A;
        #1;
        checks++;
        if (bus_out !== 4'h0) begin
            failures++;
            $display("[TB] FAIL async_rst_mem_clear got=%h exp=0", bus_out);
        end
        tick();
        rst_p  = 1'b0;
        bus_in = 8'h8F;
        tick();
        checks++;
        if (wr_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_rst_no_store got=%b exp=0", wr_pulse);
        end
        bus_in = 8'h83;
        tick();
        checks++;
        if (wr_pulse !== 1'b1 || wr_addr !== 6'd15) begin
            failures++;
            $display("[TB] FAIL async_rst_idle got=%b/%0d exp=1/15", wr_pulse, wr_addr);
        end
        bus_in = 8'h0F;
        #1;
        checks++;
        if (bus_out !== 4'h3) begin
            failures++;
            $display("[TB] FAIL async_rst_read15 got=%h exp=3", bus_out);
        end
        bus_in = 8'h0A;
        #1;
        checks++;
        if (bus_out !== 4'h0) begin
            failures++;
            $display("[TB] FAIL async_rst_read10 got=%h exp=0", bus_out);
        end
        bus_in = 8'h00;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_program();
        test_read();
        test_store();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
